// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS-subset datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath strobes.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        alu_src_b,
    output logic [5:0]  alu_func,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [31:0] retired,
    output logic [3:0]  dbg_state
);

    // Memory handshake: mem_req (with iord/mem_we) is held from the first
    // requesting cycle through the cycle in which mem_ready is seen high;
    // the access completes in that cycle and mem_ready is ignored otherwise.

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        EXEC_I = 4'd4,
        MEM    = 4'd5,
        WB_R   = 4'd6,
        WB_I   = 4'd7,
        WB_MEM = 4'd8,
        TRAP   = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_LW   = 3'd2,
        C_SW   = 3'd3,
        C_ADDI = 3'd4
    } class_t;

    localparam logic [5:0] FUNC_ADD = 6'b100000;

    state_t     state;
    state_t     state_nx;
    class_t     cls;
    class_t     dec_cls;
    logic [3:0] fn_q;
    logic       retire;

    assign dbg_state = state;

    // Instruction class straight from the IR; only captured in DECODE.
    always_comb begin
        dec_cls = C_NONE;
        case (opcode)
            6'h23: dec_cls = C_LW;
            6'h2b: dec_cls = C_SW;
            6'h08: dec_cls = C_ADDI;
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27: dec_cls = C_R;
                    default: dec_cls = C_NONE;
                endcase
            end
            default: dec_cls = C_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cls     <= C_NONE;
            fn_q    <= 4'd0;
            retired <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == DECODE) begin
                cls  <= dec_cls;
                fn_q <= funct[3:0];
            end
            if (retire) begin
                retired <= retired + 32'd1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src_b  = 1'b0;
        alu_func   = FUNC_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_nx = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                case (dec_cls)
                    C_NONE:  state_nx = TRAP;
                    C_R:     state_nx = EXEC_R;
                    default: state_nx = EXEC_I;
                endcase
            end
            EXEC_R: begin
                alu_func = {2'b10, fn_q};
                state_nx = WB_R;
            end
            EXEC_I: begin
                alu_src_b = 1'b1;
                state_nx  = (cls == C_ADDI) ? WB_I : MEM;
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (cls == C_SW);
                if (mem_ready) begin
                    if (cls == C_SW) retire = 1'b1;
                    else             state_nx = WB_MEM;
                end
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // run is only honoured at instruction boundaries
        if (retire) state_nx = run ? FETCH : IDLE;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: per-cycle checks of state,
// strobes, ALU function and retired count against hand-computed values.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_EXEC_R = 4'd3, S_EXEC_I = 4'd4, S_MEM = 4'd5,
                           S_WB_R = 4'd6, S_WB_I = 4'd7, S_WB_MEM = 4'd8,
                           S_TRAP = 4'd9;

    // {mem_req, mem_we, iord, ir_write, pc_write, alu_src_b,
    //  reg_write, reg_dst, mem_to_reg, illegal}
    localparam logic [9:0] SB_NONE  = 10'b00000_00000;
    localparam logic [9:0] SB_FWAIT = 10'b10000_00000;
    localparam logic [9:0] SB_FRDY  = 10'b10011_00000;
    localparam logic [9:0] SB_EXI   = 10'b00000_10000;
    localparam logic [9:0] SB_MLD   = 10'b10100_00000;
    localparam logic [9:0] SB_MST   = 10'b11100_00000;
    localparam logic [9:0] SB_WBR   = 10'b00000_01100;
    localparam logic [9:0] SB_WBI   = 10'b00000_01000;
    localparam logic [9:0] SB_WBM   = 10'b00000_01010;
    localparam logic [9:0] SB_TRAP  = 10'b00000_00001;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_NOR = 6'b100111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src_b;
    logic        reg_write, reg_dst, mem_to_reg, illegal;
    logic [5:0]  alu_func;
    logic [31:0] retired;
    logic [3:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_src_b  (alu_src_b),
        .alu_func   (alu_func),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .retired    (retired),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    wire [9:0] sb_obs = {mem_req, mem_we, iord, ir_write, pc_write, alu_src_b,
                         reg_write, reg_dst, mem_to_reg, illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One state cycle: r/rdy are the inputs held during the checked state
    // and sampled at its closing edge.
    task automatic cyc(input string tag, input logic r, input logic rdy,
                       input logic [3:0] st, input logic [9:0] sb,
                       input logic [5:0] fn, input logic [31:0] ret);
        @(posedge clk);
        #1;
        run       = r;
        mem_ready = rdy;
        @(negedge clk);
        chk({tag, ".state"},   32'(dbg_state), 32'(st));
        chk({tag, ".strobes"}, 32'(sb_obs),    32'(sb));
        chk({tag, ".func"},    32'(alu_func),  32'(fn));
        chk({tag, ".retired"}, retired,        ret);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type sub, run dropped during EXEC_R
        opcode = 6'h00; funct = 6'h22;
        cyc("rst",      1, 1, S_IDLE,   SB_NONE, F_ADD, 0);
        cyc("sub_f",    1, 1, S_FETCH,  SB_FRDY, F_ADD, 0);
        cyc("sub_d",    1, 1, S_DECODE, SB_NONE, F_ADD, 0);
        cyc("sub_x",    0, 1, S_EXEC_R, SB_NONE, F_SUB, 0);
        cyc("sub_wb",   0, 1, S_WB_R,   SB_WBR,  F_ADD, 0);
        cyc("sub_idle", 0, 1, S_IDLE,   SB_NONE, F_ADD, 1);

        // lw with two wait cycles, then sw back to back
        opcode = 6'h23;
        cyc("lw_idle", 1, 1, S_IDLE,   SB_NONE, F_ADD, 1);
        cyc("lw_f",    1, 1, S_FETCH,  SB_FRDY, F_ADD, 1);
        cyc("lw_d",    1, 1, S_DECODE, SB_NONE, F_ADD, 1);
        cyc("lw_x",    1, 1, S_EXEC_I, SB_EXI,  F_ADD, 1);
        cyc("lw_m0",   1, 0, S_MEM,    SB_MLD,  F_ADD, 1);
        cyc("lw_m1",   1, 0, S_MEM,    SB_MLD,  F_ADD, 1);
        cyc("lw_m2",   1, 1, S_MEM,    SB_MLD,  F_ADD, 1);
        cyc("lw_wb",   1, 1, S_WB_MEM, SB_WBM,  F_ADD, 1);
        opcode = 6'h2b;
        cyc("sw_fw",   1, 0, S_FETCH,  SB_FWAIT, F_ADD, 2);
        cyc("sw_f",    1, 1, S_FETCH,  SB_FRDY,  F_ADD, 2);
        cyc("sw_d",    1, 1, S_DECODE, SB_NONE,  F_ADD, 2);
        cyc("sw_x",    1, 1, S_EXEC_I, SB_EXI,   F_ADD, 2);
        cyc("sw_m",    0, 1, S_MEM,    SB_MST,   F_ADD, 2);
        cyc("sw_idle", 0, 1, S_IDLE,   SB_NONE,  F_ADD, 3);

        // addi then nor back to back
        opcode = 6'h08;
        cyc("addi_idle", 1, 1, S_IDLE,   SB_NONE, F_ADD, 3);
        cyc("addi_f",    1, 1, S_FETCH,  SB_FRDY, F_ADD, 3);
        cyc("addi_d",    1, 1, S_DECODE, SB_NONE, F_ADD, 3);
        cyc("addi_x",    1, 1, S_EXEC_I, SB_EXI,  F_ADD, 3);
        cyc("addi_wb",   1, 1, S_WB_I,   SB_WBI,  F_ADD, 3);
        opcode = 6'h00; funct = 6'h27;
        cyc("nor_f",     1, 1, S_FETCH,  SB_FRDY, F_ADD, 4);
        cyc("nor_d",     1, 1, S_DECODE, SB_NONE, F_ADD, 4);
        cyc("nor_x",     1, 1, S_EXEC_R, SB_NONE, F_NOR, 4);
        cyc("nor_wb",    0, 1, S_WB_R,   SB_WBR,  F_ADD, 4);
        cyc("nor_idle",  0, 1, S_IDLE,   SB_NONE, F_ADD, 5);

        // unsupported opcode traps and holds through run toggling
        opcode = 6'h04;
        cyc("trap_idle", 1, 1, S_IDLE,   SB_NONE, F_ADD, 5);
        cyc("trap_f",    1, 1, S_FETCH,  SB_FRDY, F_ADD, 5);
        cyc("trap_d",    1, 1, S_DECODE, SB_NONE, F_ADD, 5);
        for (int i = 0; i < 10; i++) begin
            cyc("trap_hold", i[0], i[1], S_TRAP, SB_TRAP, F_ADD, 5);
        end
        rst_n = 1'b0;
        cyc("trap_rst", 0, 0, S_IDLE, SB_NONE, F_ADD, 0);
        rst_n = 1'b1;

        // reset during a fetch wait abandons the request
        opcode = 6'h00; funct = 6'h20;
        cyc("fr_idle", 1, 0, S_IDLE,  SB_NONE,  F_ADD, 0);
        cyc("fr_fw0",  1, 0, S_FETCH, SB_FWAIT, F_ADD, 0);
        cyc("fr_fw1",  1, 0, S_FETCH, SB_FWAIT, F_ADD, 0);
        rst_n = 1'b0;
        cyc("fr_rst",  1, 0, S_IDLE,  SB_NONE,  F_ADD, 0);
        rst_n = 1'b1;
        cyc("add_f",    1, 1, S_FETCH,  SB_FRDY, F_ADD, 0);
        cyc("add_d",    1, 1, S_DECODE, SB_NONE, F_ADD, 0);
        cyc("add_x",    1, 1, S_EXEC_R, SB_NONE, F_ADD, 0);
        cyc("add_wb",   0, 1, S_WB_R,   SB_WBR,  F_ADD, 0);
        cyc("add_idle", 0, 1, S_IDLE,   SB_NONE, F_ADD, 1);

        // retired counter wraps from all-ones
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        cyc("wrap_idle", 1, 1, S_IDLE,   SB_NONE, F_ADD, 32'hFFFF_FFFF);
        cyc("wrap_f",    1, 1, S_FETCH,  SB_FRDY, F_ADD, 32'hFFFF_FFFF);
        cyc("wrap_d",    1, 1, S_DECODE, SB_NONE, F_ADD, 32'hFFFF_FFFF);
        cyc("wrap_x",    1, 1, S_EXEC_R, SB_NONE, F_ADD, 32'hFFFF_FFFF);
        cyc("wrap_wb",   0, 1, S_WB_R,   SB_WBR,  F_ADD, 32'hFFFF_FFFF);
        cyc("wrap_idle2", 0, 1, S_IDLE,  SB_NONE, F_ADD, 0);

        // R-type with an unsupported funct also traps
        funct = 6'h21;
        cyc("badf_idle", 1, 1, S_IDLE,   SB_NONE, F_ADD, 0);
        cyc("badf_f",    1, 1, S_FETCH,  SB_FRDY, F_ADD, 0);
        cyc("badf_d",    1, 1, S_DECODE, SB_NONE, F_ADD, 0);
        cyc("badf_t",    0, 0, S_TRAP,   SB_TRAP, F_ADD, 0);
        rst_n = 1'b0;
        cyc("badf_rst",  0, 0, S_IDLE,   SB_NONE, F_ADD, 0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
